// File: rtl/quad_encoder_counter_pkg.sv
// Shared decode definitions for the quadrature encoder counter.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
//
// Contents: transition classification enum, the Gray up-count successor
// table and a classifier built on that table.
package quad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN,
    ILLEGAL
  } trans_e;

  // Up-count successor of each AB code, packed 2 bits per entry and indexed
  // by the current code: 00->01, 01->11, 11->10, 10->00.
  localparam logic [7:0] GRAY_UP_NEXT = 8'b10_00_11_01;

  function automatic logic [1:0] gray_up_next(input logic [1:0] ab);
    return GRAY_UP_NEXT[{ab, 1'b0} +: 2];
  endfunction

  // A step is UP when cur follows prev in the up sequence and DOWN when prev
  // follows cur; anything else that differs is a two-bit jump.
  function automatic trans_e classify(input logic [1:0] prev_ab,
                                      input logic [1:0] cur_ab);
    trans_e t;
    t = ILLEGAL;
    if (cur_ab == prev_ab) begin
      t = IDLE;
    end else if (cur_ab == gray_up_next(prev_ab)) begin
      t = UP;
    end else if (prev_ab == gray_up_next(cur_ab)) begin
      t = DOWN;
    end
    return t;
  endfunction

endpackage

// File: rtl/quad_encoder_counter_input_filter.sv
// Synchronises one asynchronous encoder phase and rejects short pulses.
// Latency: filt_o follows a held raw_i change FILTER_LEN+2 clock edges after first sampling.
// Backpressure: none; free-running.
//
// Ports:
//   clk_i  in  1  clock
//   rst_i  in  1  asynchronous active-high reset
//   raw_i  in  1  asynchronous phase input
//   filt_o out 1  synchronised, glitch-filtered phase
module quad_input_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic filt_o
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic             meta_q;
  logic             sync_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The synchronised value is a single bit, so any change of it either makes
  // it equal to filt_q (count cleared below) or starts a new disagreement from
  // a count that is already zero. No separate previous-value flop is needed
  // to restart the count.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_q != filt_q) begin
      if (cnt_q + CNT_W'(1) == CNT_W'(FILTER_LEN)) begin
        filt_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/quad_encoder_counter.sv
// Quadrature encoder reader: filtered A/B decode into a click-scaled position.
// Latency: COUNT/STEP update FILTER_LEN+3 edges after the first edge sampling a new A/B level.
// Backpressure: none; inputs are sampled every cycle, STEP is a one-cycle strobe.
//
// Ports:
//   CLOCK, RESET        clock and asynchronous active-high reset
//   A, B                asynchronous encoder phases
//   CLEAR, LOAD         synchronous clear / load of position (CLEAR wins)
//   LOAD_VALUE          click value for LOAD, clamped to MAX_CLICKS
//   COUNT               position in clicks
//   DIR, STEP           direction of last accepted edge, count-change strobe
//   ERROR, ERROR_CLR    sticky two-bit-jump flag and its clear (set wins)
//   VELOCITY            signed edges per window (only with QUAD_VELOCITY_EN)
// Build option: define QUAD_VELOCITY_EN to add WINDOW_CYCLES and VELOCITY.
module quad_encoder_counter
  import quad_pkg::*;
#(
  parameter int COUNT_W    = 8,
  parameter int EDGES_LOG2 = 2,
  parameter int FILTER_LEN = 3,
  parameter int MAX_CLICKS = 255,
  parameter int WRAP       = 0
`ifdef QUAD_VELOCITY_EN
  ,
  parameter int WINDOW_CYCLES = 1 << 20
`endif
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               A,
  input  logic               B,
  input  logic               CLEAR,
  input  logic               LOAD,
  input  logic [COUNT_W-1:0] LOAD_VALUE,
  output logic [COUNT_W-1:0] COUNT,
  output logic               DIR,
  output logic               STEP,
  output logic               ERROR,
  input  logic               ERROR_CLR
`ifdef QUAD_VELOCITY_EN
  ,
  output logic signed [COUNT_W+EDGES_LOG2-1:0] VELOCITY
`endif
);

  localparam int TW = COUNT_W + EDGES_LOG2;
  localparam logic [COUNT_W-1:0] MAX_C     = COUNT_W'(MAX_CLICKS);
  // Highest edge total reachable by counting up in saturate mode.
  localparam logic [TW-1:0]      MAX_TOTAL = TW'(MAX_CLICKS << EDGES_LOG2);
  // Last edge of the top click; wrap mode cycles through 0..WRAP_TOP.
  localparam logic [TW-1:0]      WRAP_TOP  =
    TW'((MAX_CLICKS << EDGES_LOG2) + (1 << EDGES_LOG2) - 1);

  logic          a_filt, b_filt;
  logic [1:0]    ab_cur;
  logic [1:0]    ab_prev_q;
  trans_e        trans;

  logic [TW-1:0]      total_q, total_d;
  logic [COUNT_W-1:0] load_clicks;
  logic [TW-1:0]      load_total;
  logic               dir_q, dir_d;
  logic               step_q, step_d;
  logic               error_q, error_d;

  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk_i  (CLOCK),
    .rst_i  (RESET),
    .raw_i  (A),
    .filt_o (a_filt)
  );

  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk_i  (CLOCK),
    .rst_i  (RESET),
    .raw_i  (B),
    .filt_o (b_filt)
  );

  assign ab_cur      = {a_filt, b_filt};
  assign trans       = classify(ab_prev_q, ab_cur);
  assign load_clicks = (LOAD_VALUE > MAX_C) ? MAX_C : LOAD_VALUE;
  assign load_total  = TW'(load_clicks) << EDGES_LOG2;

  always_comb begin
    total_d = total_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    error_d = error_q;

    if (ERROR_CLR) begin
      error_d = 1'b0;
    end
    if (trans == ILLEGAL) begin
      error_d = 1'b1;
    end

    // An edge coinciding with CLEAR/LOAD is dropped entirely, DIR included.
    if (CLEAR) begin
      total_d = '0;
    end else if (LOAD) begin
      total_d = load_total;
    end else if (trans == UP) begin
      dir_d = 1'b1;
      if (WRAP != 0) begin
        total_d = (total_q >= WRAP_TOP) ? '0 : total_q + TW'(1);
      end else begin
        total_d = (total_q >= MAX_TOTAL) ? total_q : total_q + TW'(1);
      end
      step_d = (total_d[TW-1:EDGES_LOG2] != total_q[TW-1:EDGES_LOG2]);
    end else if (trans == DOWN) begin
      dir_d = 1'b0;
      if (total_q == '0) begin
        total_d = (WRAP != 0) ? WRAP_TOP : total_q;
      end else begin
        total_d = total_q - TW'(1);
      end
      step_d = (total_d[TW-1:EDGES_LOG2] != total_q[TW-1:EDGES_LOG2]);
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      ab_prev_q <= 2'b00;
      total_q   <= '0;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      ab_prev_q <= ab_cur;
      total_q   <= total_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      error_q   <= error_d;
    end
  end

  assign COUNT = total_q[TW-1:EDGES_LOG2];
  assign DIR   = dir_q;
  assign STEP  = step_q;
  assign ERROR = error_q;

`ifdef QUAD_VELOCITY_EN
  // Velocity reflects physical motion: every legal decoded edge counts, even
  // when saturation blocks it or CLEAR/LOAD discards it from the position.
  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [TW-1:0] ACC_ONE = TW'(1);
  localparam logic [TW-1:0] ACC_MAX = {1'b0, {(TW-1){1'b1}}};
  localparam logic [TW-1:0] ACC_MIN = {1'b1, {(TW-1){1'b0}}};

  logic [WIN_W-1:0] win_q, win_d;
  logic [TW-1:0]    acc_q, acc_d, acc_step;
  logic [TW-1:0]    vel_q, vel_d;

  always_comb begin
    acc_step = acc_q;
    if (trans == UP && acc_q != ACC_MAX) begin
      acc_step = acc_q + ACC_ONE;
    end else if (trans == DOWN && acc_q != ACC_MIN) begin
      acc_step = acc_q - ACC_ONE;
    end
    win_d = win_q + WIN_W'(1);
    acc_d = acc_step;
    vel_d = vel_q;
    if (win_q == WIN_W'(WINDOW_CYCLES - 1)) begin
      win_d = '0;
      acc_d = '0;
      vel_d = acc_step;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      win_q <= '0;
      acc_q <= '0;
      vel_q <= '0;
    end else begin
      win_q <= win_d;
      acc_q <= acc_d;
      vel_q <= vel_d;
    end
  end

  assign VELOCITY = vel_q;
`endif

endmodule

// File: tb/tb_quad_encoder_counter.sv
`timescale 1ns/1ps
module tb_quad_encoder_counter;

  localparam int FL    = 3;
  localparam int LAT   = FL + 3;
  localparam int ND    = 3;
  localparam int SLOT  = 10;
  localparam int MAXC  = 255;
  localparam int TOPE  = MAXC * 4;
  localparam int MODW  = (MAXC + 1) * 4;

  logic       CLOCK = 1'b0;
  logic       RESET, A, B, CLEAR, LOAD, ERROR_CLR;
  logic [8:0] ld_val;
  logic [7:0] cnt0, cnt1;
  logic [8:0] cnt2;
  logic [ND-1:0] dir_o, step_o, err_o;
`ifdef QUAD_VELOCITY_EN
  logic signed [9:0]  vel0, vel1;
  logic signed [10:0] vel2;
`endif

  always #5 CLOCK = ~CLOCK;

  // u0: saturating 8-bit, u1: wrapping 8-bit, u2: saturating 9-bit with MAX 255
  quad_encoder_counter #(.COUNT_W(8), .FILTER_LEN(FL), .MAX_CLICKS(MAXC), .WRAP(0)) u0 (
    .CLOCK(CLOCK), .RESET(RESET), .A(A), .B(B), .CLEAR(CLEAR), .LOAD(LOAD),
    .LOAD_VALUE(ld_val[7:0]), .COUNT(cnt0), .DIR(dir_o[0]), .STEP(step_o[0]),
    .ERROR(err_o[0]), .ERROR_CLR(ERROR_CLR)
`ifdef QUAD_VELOCITY_EN
    , .VELOCITY(vel0)
`endif
  );
  quad_encoder_counter #(.COUNT_W(8), .FILTER_LEN(FL), .MAX_CLICKS(MAXC), .WRAP(1)) u1 (
    .CLOCK(CLOCK), .RESET(RESET), .A(A), .B(B), .CLEAR(CLEAR), .LOAD(LOAD),
    .LOAD_VALUE(ld_val[7:0]), .COUNT(cnt1), .DIR(dir_o[1]), .STEP(step_o[1]),
    .ERROR(err_o[1]), .ERROR_CLR(ERROR_CLR)
`ifdef QUAD_VELOCITY_EN
    , .VELOCITY(vel1)
`endif
  );
  quad_encoder_counter #(.COUNT_W(9), .FILTER_LEN(FL), .MAX_CLICKS(MAXC), .WRAP(0)) u2 (
    .CLOCK(CLOCK), .RESET(RESET), .A(A), .B(B), .CLEAR(CLEAR), .LOAD(LOAD),
    .LOAD_VALUE(ld_val), .COUNT(cnt2), .DIR(dir_o[2]), .STEP(step_o[2]),
    .ERROR(err_o[2]), .ERROR_CLR(ERROR_CLR)
`ifdef QUAD_VELOCITY_EN
    , .VELOCITY(vel2)
`endif
  );

  typedef struct {
    int cnt;
    int dir;
    int cyc;
  } exp_t;

  exp_t sbq [ND][$];
  exp_t mon_e;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Reference model: position in edges per instance, plus the Gray position
  // of the level currently held on A/B.
  int m_tot [ND];
  int m_dir [ND];
  int m_err [ND];
  int m_idx;
  int wrap_mode [ND] = '{0, 1, 0};
  int ld_mask   [ND] = '{255, 255, 511};

  always @(posedge CLOCK) cyc = cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int cnt_of(input int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  function automatic logic [1:0] gray(input int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Scoreboard monitor: every STEP pulse must match the oldest expectation.
  always @(negedge CLOCK) begin
    for (int k = 0; k < ND; k++) begin
      if (step_o[k] === 1'b1) begin
        chk($sformatf("u%0d STEP expected", k), int'(sbq[k].size() > 0), 1);
        if (sbq[k].size() > 0) begin
          mon_e = sbq[k].pop_front();
          chk($sformatf("u%0d COUNT at STEP", k), cnt_of(k), mon_e.cnt);
          chk($sformatf("u%0d DIR at STEP", k), int'(dir_o[k]), mon_e.dir);
          chk($sformatf("u%0d STEP cycle", k), cyc, mon_e.cyc);
        end
      end
    end
  end

  // kind: 1 up, -1 down, 2 two-bit jump
  task automatic drive_move(input int kind);
    m_idx = (m_idx + ((kind == 2) ? 2 : (kind == 1) ? 1 : 3)) % 4;
    {A, B} = gray(m_idx);
  endtask

  task automatic model_edge(input int kind, input int c);
    int old, nw;
    for (int k = 0; k < ND; k++) begin
      if (kind == 2) begin
        m_err[k] = 1;
      end else begin
        old = m_tot[k];
        m_dir[k] = (kind > 0) ? 1 : 0;
        if (wrap_mode[k] != 0) begin
          nw = (old + kind + MODW) % MODW;
        end else begin
          nw = old + kind;
          if (nw < 0) nw = 0;
          if (nw > TOPE) nw = TOPE;
        end
        m_tot[k] = nw;
        if (nw / 4 != old / 4) sbq[k].push_back('{nw / 4, m_dir[k], c + LAT});
      end
    end
  endtask

  task automatic model_load(input int v);
    int lv;
    for (int k = 0; k < ND; k++) begin
      lv = v & ld_mask[k];
      m_tot[k] = ((lv > MAXC) ? MAXC : lv) * 4;
    end
  endtask

  task automatic slot_check();
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("u%0d COUNT", k), cnt_of(k), m_tot[k] / 4);
      chk($sformatf("u%0d DIR", k), int'(dir_o[k]), m_dir[k]);
      chk($sformatf("u%0d ERROR", k), int'(err_o[k]), m_err[k]);
      chk($sformatf("u%0d missing STEP", k), sbq[k].size(), 0);
    end
  endtask

  task automatic settle();
    repeat (SLOT) @(negedge CLOCK);
    slot_check();
  endtask

  task automatic op_move(input int kind);
    int c;
    c = cyc;
    drive_move(kind);
    model_edge(kind, c);
    settle();
  endtask

  task automatic op_glitch(input int g);
    A = ~A;
    repeat (g) @(negedge CLOCK);
    A = ~A;
    settle();
  endtask

  task automatic op_clear();
    CLEAR = 1'b1;
    @(negedge CLOCK);
    CLEAR = 1'b0;
    for (int k = 0; k < ND; k++) m_tot[k] = 0;
    settle();
  endtask

  task automatic op_load(input int v);
    ld_val = 9'(v);
    LOAD = 1'b1;
    @(negedge CLOCK);
    LOAD = 1'b0;
    model_load(v);
    settle();
  endtask

  task automatic op_errclr();
    ERROR_CLR = 1'b1;
    @(negedge CLOCK);
    ERROR_CLR = 1'b0;
    for (int k = 0; k < ND; k++) m_err[k] = 0;
    settle();
  endtask

  // Legal edge reaching the decoder in the same cycle as LOAD: edge dropped.
  task automatic op_move_load(input int kind, input int v);
    drive_move(kind);
    repeat (LAT - 1) @(negedge CLOCK);
    ld_val = 9'(v);
    LOAD = 1'b1;
    @(negedge CLOCK);
    LOAD = 1'b0;
    model_load(v);
    settle();
  endtask

  // Two-bit jump reaching the decoder in the same cycle as ERROR_CLR.
  task automatic op_illegal_errclr();
    drive_move(2);
    repeat (LAT - 1) @(negedge CLOCK);
    ERROR_CLR = 1'b1;
    @(negedge CLOCK);
    ERROR_CLR = 1'b0;
    for (int k = 0; k < ND; k++) m_err[k] = 1;
    settle();
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("%s u%0d COUNT", tag, k), cnt_of(k), 0);
      chk($sformatf("%s u%0d DIR", tag, k), int'(dir_o[k]), 0);
      chk($sformatf("%s u%0d STEP", tag, k), int'(step_o[k]), 0);
      chk($sformatf("%s u%0d ERROR", tag, k), int'(err_o[k]), 0);
    end
  endtask

  task automatic model_reset();
    m_idx = 0;
    for (int k = 0; k < ND; k++) begin
      m_tot[k] = 0;
      m_dir[k] = 0;
      m_err[k] = 0;
      sbq[k].delete();
    end
  endtask

  initial begin
    int r;
    RESET = 1'b0; A = 1'b0; B = 1'b0; CLEAR = 1'b0; LOAD = 1'b0;
    ERROR_CLR = 1'b0; ld_val = '0;
    model_reset();
    #2 RESET = 1'b1;
    #2 check_all_zero("reset");
    repeat (3) @(negedge CLOCK);
    RESET = 1'b0;
    @(negedge CLOCK);

    // 8 up edges -> 2 clicks
    for (int i = 0; i < 8; i++) op_move(1);
    // short glitches on A are rejected
    op_glitch(1);
    op_glitch(2);
    // down from 0: saturate holds, wrap goes to top click; then back up
    op_clear();
    for (int i = 0; i < 4; i++) op_move(-1);
    for (int i = 0; i < 4; i++) op_move(1);
    // saturate at the top click
    op_load(255);
    for (int i = 0; i < 8; i++) op_move(1);
    // two-bit jumps and ERROR handling
    op_move(2);
    op_illegal_errclr();
    op_errclr();
    // oversize LOAD with a colliding edge
    op_move_load(1, 300);
    op_move_load(-1, 7);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      op_move(1);
      else if (r < 75) op_move(-1);
      else if (r < 80) op_move(2);
      else if (r < 86) op_glitch($urandom_range(1, 2));
      else if (r < 90) op_clear();
      else if (r < 95) op_load($urandom_range(0, 511));
      else if (r < 97) op_errclr();
      else             op_move_load(($urandom_range(0, 1) == 1) ? 1 : -1,
                                    $urandom_range(0, 511));
    end

    // reset in the middle of a filter count clears everything at once
    op_load(100);
    op_move(1);
    drive_move(1);
    repeat (3) @(negedge CLOCK);
    #2 RESET = 1'b1;
    #1 check_all_zero("mid-reset");
    A = 1'b0;
    B = 1'b0;
    model_reset();
    repeat (3) @(negedge CLOCK);
    RESET = 1'b0;
    settle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
